// File: rtl/noise_pkg.sv
// Shared constants for the noise LFSR: maximal feedback masks per width and short-mode taps.
package noise_pkg;

  localparam int SHORT_TAP_HI = 6;
  localparam int SHORT_TAP_LO = 5;
  localparam int SEED_DEFAULT = 1;

  // Fibonacci masks (bit k = stage k) giving maximal-length sequences for widths 8..24
  function automatic logic [31:0] default_taps(input int n);
    case (n)
      8:  return 32'h0000_00B8;
      9:  return 32'h0000_0110;
      10: return 32'h0000_0240;
      11: return 32'h0000_0500;
      12: return 32'h0000_0E08;
      13: return 32'h0000_1C80;
      14: return 32'h0000_3802;
      15: return 32'h0000_6000;
      16: return 32'h0000_B400;
      17: return 32'h0001_2000;
      18: return 32'h0002_0400;
      19: return 32'h0007_2000;
      20: return 32'h0009_0000;
      21: return 32'h0014_0000;
      22: return 32'h0030_0000;
      23: return 32'h0042_0000;
      24: return 32'h00E1_0000;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/clk_en_divider.sv
// Enabled-cycle rate divider: one step pulse per (div+1) enabled cycles.
module clk_en_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             step
);

  logic [DIV_W-1:0] cnt;

  // >= so lowering div below the running count steps on the next enabled cycle
  assign step = en && (cnt >= div);

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en) begin
      if (step) cnt <= '0;
      else      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_noise_gen.sv
// Parametrised LFSR noise source with rate divider, seed load, short-period mode and lock-up recovery.
module lfsr_noise_gen
  import noise_pkg::*;
#(
  parameter int             N            = 16,
  parameter int             M            = 12,
  parameter logic [N-1:0]   TAPS         = N'(default_taps(N)),
  parameter logic [N-1:0]   SEED_DEFAULT = N'(noise_pkg::SEED_DEFAULT),
  parameter int             DIV_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             short_mode,
  input  logic             seed_load,
  input  logic [N-1:0]     seed,
  output logic [M-1:0]     noise,
  output logic             noise_valid,
  output logic             lockup
);

  if (N < 8)              begin : g_bad_n    $error("lfsr_noise_gen: N must be >= 8");        end
  if (M > N)              begin : g_bad_m    $error("lfsr_noise_gen: M must be <= N");        end
  if (TAPS == '0)         begin : g_bad_taps $error("lfsr_noise_gen: TAPS must be nonzero");  end
  if (SEED_DEFAULT == '0) begin : g_bad_seed $error("lfsr_noise_gen: SEED_DEFAULT nonzero");  end

  logic [N-1:0] shift;
  logic         step;
  logic         fb;
  logic         stuck;

  clk_en_divider #(.DIV_W(DIV_W)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (seed_load),
    .div  (div),
    .step (step)
  );

  // Short mode only watches the 7-bit sub-register that drives feedback
  always_comb begin
    fb    = short_mode ? (shift[SHORT_TAP_HI] ^ shift[SHORT_TAP_LO]) : ^(shift & TAPS);
    stuck = short_mode ? (shift[SHORT_TAP_HI:0] == '0) : (shift == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift       <= SEED_DEFAULT;
      noise_valid <= 1'b0;
      lockup      <= 1'b0;
    end else begin
      noise_valid <= 1'b0;
      lockup      <= 1'b0;
      if (seed_load) begin
        if (seed == '0) begin
          shift  <= SEED_DEFAULT;
          lockup <= 1'b1;
        end else begin
          shift  <= seed;
        end
      end else if (step) begin
        noise_valid <= 1'b1;
        if (stuck) begin
          shift  <= SEED_DEFAULT;
          lockup <= 1'b1;
        end else begin
          shift  <= {shift[N-2:0], fb};
        end
      end
    end
  end

  assign noise = shift[N-1 -: M];

endmodule

// File: tb/tb_lfsr_noise_gen.sv
// Scoreboard bench for lfsr_noise_gen: driver pushes expected output events, monitor pops and compares.
module tb_lfsr_noise_gen;

  logic        clk = 1'b0;
  logic        rst, en, short_mode, seed_load;
  logic [15:0] div, seed;
  logic [11:0] noise;
  logic        noise_valid, lockup;

  lfsr_noise_gen dut (
    .clk(clk), .rst(rst), .en(en), .div(div), .short_mode(short_mode),
    .seed_load(seed_load), .seed(seed), .noise(noise),
    .noise_valid(noise_valid), .lockup(lockup)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit done  = 1'b0;
  logic [13:0] exp_q[$];   // {noise, noise_valid, lockup}
  logic [15:0] m_shift, m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // One clock: apply inputs, advance the reference model, queue the event it predicts
  task automatic cyc(input logic r, input logic e, input logic [15:0] d,
                     input logic sm, input logic sl, input logic [15:0] sd);
    logic v, lk, f;
    rst = r; en = e; div = d; short_mode = sm; seed_load = sl; seed = sd;
    v = 1'b0; lk = 1'b0;
    if (r) begin
      m_shift = 16'h0001; m_cnt = '0;
    end else if (sl) begin
      m_cnt = '0;
      if (sd == 16'h0) begin m_shift = 16'h0001; lk = 1'b1; end
      else m_shift = sd;
    end else if (e) begin
      if (m_cnt >= d) begin
        m_cnt = '0; v = 1'b1;
        if (sm ? (m_shift[6:0] == 7'h0) : (m_shift == 16'h0)) begin
          m_shift = 16'h0001; lk = 1'b1;
        end else begin
          f = sm ? (m_shift[6] ^ m_shift[5])
                 : (m_shift[15] ^ m_shift[13] ^ m_shift[12] ^ m_shift[10]);
          m_shift = {m_shift[14:0], f};
        end
      end else m_cnt = m_cnt + 16'd1;
    end
    if (v || lk) exp_q.push_back({m_shift[15:4], v, lk});
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!done && (noise_valid || lockup)) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL spurious_event: noise=0x%0h valid=%0b lockup=%0b, none expected",
                 noise, noise_valid, lockup);
      end else begin
        check("event", {noise, noise_valid, lockup}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int k;
    logic [15:0] ref_s;

    // 1: reset state, then single-cycle steps from 0x0001
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("reset_noise", noise, 12'h000);
    check("reset_valid", noise_valid, 0);
    check("reset_lockup", lockup, 0);
    check("reset_shift", dut.shift, 16'h0001);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0, 0);
    check("step10_shift", dut.shift, 16'h0400);
    check("step10_noise", noise, 12'h040);
    cyc(0, 1, 0, 0, 0, 0);
    check("step11_shift", dut.shift, 16'h0801);
    check("step11_noise", noise, 12'h080);

    // 2: full long-mode period
    cyc(1, 0, 0, 0, 0, 0);
    k = 0;
    for (int i = 1; i <= 70000; i++) begin
      cyc(0, 1, 0, 0, 0, 0);
      if (dut.shift == 16'h0001) begin k = i; break; end
    end
    check("long_period", k, 65535);

    // 3: div=3 with an en=0 freeze
    cyc(1, 0, 3, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 3, 0, 0, 0);
    check("div_cnt_pre", dut.u_div.cnt, 2);
    for (int i = 0; i < 5; i++) cyc(0, 0, 3, 0, 0, 0);
    check("div_cnt_frozen", dut.u_div.cnt, 2);
    for (int i = 0; i < 9; i++) cyc(0, 1, 3, 0, 0, 0);
    check("div_cnt_resumed", dut.u_div.cnt, 3);

    // 4: seed loads
    cyc(0, 0, 0, 0, 1, 16'h0000);
    check("seed0_shift", dut.shift, 16'h0001);
    check("seed0_valid", noise_valid, 0);
    check("seed0_lockup", lockup, 1);
    cyc(0, 0, 0, 0, 1, 16'hACE1);
    check("seedACE1_noise", noise, 12'hACE);
    check("seedACE1_lockup", lockup, 0);

    // 5: short mode period and forced lock-up
    cyc(0, 1, 0, 1, 1, 16'h0001);
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 1, 0, 0);
    ref_s = dut.shift;
    k = 0;
    for (int i = 1; i <= 300; i++) begin
      cyc(0, 1, 0, 1, 0, 0);
      if (dut.shift == ref_s) begin k = i; break; end
    end
    check("short_period", k, 127);
    cyc(0, 0, 0, 1, 1, 16'h0080);
    check("short_seed80", noise, 12'h008);
    cyc(0, 1, 0, 1, 0, 0);
    check("short_recover_shift", dut.shift, 16'h0001);
    check("short_recover_lockup", lockup, 1);
    check("short_recover_valid", noise_valid, 1);

    // 6: seed_load vs pending step, rst vs seed_load
    cyc(1, 0, 2, 0, 0, 0);
    cyc(0, 1, 2, 0, 0, 0);
    cyc(0, 1, 2, 0, 0, 0);
    cyc(0, 1, 2, 0, 1, 16'h1234);
    check("coinc_noise", noise, 12'h123);
    check("coinc_valid", noise_valid, 0);
    check("coinc_cnt", dut.u_div.cnt, 0);
    cyc(0, 1, 2, 0, 0, 0);
    cyc(1, 1, 2, 0, 1, 16'hFFFF);
    check("rst_sl_shift", dut.shift, 16'h0001);
    check("rst_sl_noise", noise, 12'h000);
    check("rst_sl_cnt", dut.u_div.cnt, 0);
    check("rst_sl_lockup", lockup, 0);

    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("queue_drained", exp_q.size(), 0);
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
